// File: rtl/vector_reg_read.sv
// vector_reg_read: operand-fetch stage for the vector ALU.
// Reads up to 8 consecutive register-file elements starting at a base address, one request per
// clock, and assembles them onto eight parallel operand outputs. A one-cycle done pulse marks
// completion.
module vector_reg_read #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              pc_rst_n,
  input  logic              VRR_Ena,
  input  logic [31:0]       VLR,
  input  logic [ADDR_W-1:0] Base_Addr,
  output logic              Read_En,
  output logic [ADDR_W-1:0] Read_Addr,
  input  logic [DATA_W-1:0] Read_Data,
  output logic [DATA_W-1:0] VOp_0,
  output logic [DATA_W-1:0] VOp_1,
  output logic [DATA_W-1:0] VOp_2,
  output logic [DATA_W-1:0] VOp_3,
  output logic [DATA_W-1:0] VOp_4,
  output logic [DATA_W-1:0] VOp_5,
  output logic [DATA_W-1:0] VOp_6,
  output logic [DATA_W-1:0] VOp_7,
  output logic              VRR_busy,
  output logic              VRR_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [3:0]        eff_q, eff_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        iidx_q, iidx_d;
  logic [3:0]        widx_q, widx_d;
  logic              pend_q;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] vop_q [8];
  logic [DATA_W-1:0] vop_d [8];

  logic [3:0] eff_in;
  logic [3:0] widx_inc;
  logic [3:0] widx_after;

  assign eff_in     = (VLR > 32'd8) ? 4'd8 : VLR[3:0];
  assign widx_inc   = widx_q + 4'd1;
  // Write index as it will stand after this clock's capture, if any.
  assign widx_after = pend_q ? widx_inc : widx_q;

  // Next-state, request generation and operand capture.
  always_comb begin
    state_d = state_q;
    eff_d   = eff_q;
    base_d  = base_q;
    iidx_d  = iidx_q;
    widx_d  = widx_q;
    ren_d   = ren_q;
    raddr_d = raddr_q;
    vop_d   = vop_q;

    // Data for a request issued two edges ago is on Read_Data now, regardless of state.
    if (pend_q) begin
      vop_d[widx_q[2:0]] = Read_Data;
      widx_d             = widx_inc;
    end

    case (state_q)
      IDLE: begin
        if (VRR_Ena) begin
          eff_d  = eff_in;
          base_d = Base_Addr;
          iidx_d = 4'd0;
          widx_d = 4'd0;
          vop_d  = '{default: '0};
          if (eff_in == 4'd0) begin
            // An empty vector still spends one cycle in DRAIN so done lands at start+eff+1.
            state_d = DRAIN;
          end else begin
            state_d = ISSUE;
            ren_d   = 1'b1;
            raddr_d = Base_Addr;
          end
        end
      end
      ISSUE: begin
        if (iidx_q == eff_q - 4'd1) begin
          ren_d   = 1'b0;
          state_d = DRAIN;
        end else begin
          iidx_d  = iidx_q + 4'd1;
          raddr_d = base_q + ADDR_W'(iidx_q + 4'd1);
        end
      end
      DRAIN: begin
        if (widx_after == eff_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      state_q <= IDLE;
      eff_q   <= 4'd0;
      base_q  <= '0;
      iidx_q  <= 4'd0;
      widx_q  <= 4'd0;
      pend_q  <= 1'b0;
      ren_q   <= 1'b0;
      raddr_q <= '0;
      vop_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      eff_q   <= eff_d;
      base_q  <= base_d;
      iidx_q  <= iidx_d;
      widx_q  <= widx_d;
      pend_q  <= ren_q;
      ren_q   <= ren_d;
      raddr_q <= raddr_d;
      vop_q   <= vop_d;
    end
  end

  assign Read_En   = ren_q;
  assign Read_Addr = raddr_q;
  assign VRR_busy  = (state_q != IDLE);
  assign VRR_done  = (state_q == DONE);
  assign VOp_0     = vop_q[0];
  assign VOp_1     = vop_q[1];
  assign VOp_2     = vop_q[2];
  assign VOp_3     = vop_q[3];
  assign VOp_4     = vop_q[4];
  assign VOp_5     = vop_q[5];
  assign VOp_6     = vop_q[6];
  assign VOp_7     = vop_q[7];

endmodule

// File: tb/tb_vector_reg_read.sv
// Bench for vector_reg_read: timeline reference model plus directed and random operations.
module tb_vector_reg_read;

  logic        clk = 1'b0;
  logic        pc_rst_n;
  logic        VRR_Ena;
  logic [31:0] VLR;
  logic [4:0]  Base_Addr;
  logic        Read_En;
  logic [4:0]  Read_Addr;
  logic [31:0] Read_Data;
  logic [31:0] vop0, vop1, vop2, vop3, vop4, vop5, vop6, vop7;
  logic [31:0] vop [8];
  logic        VRR_busy;
  logic        VRR_done;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  vector_reg_read #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .pc_rst_n  (pc_rst_n),
    .VRR_Ena   (VRR_Ena),
    .VLR       (VLR),
    .Base_Addr (Base_Addr),
    .Read_En   (Read_En),
    .Read_Addr (Read_Addr),
    .Read_Data (Read_Data),
    .VOp_0     (vop0),
    .VOp_1     (vop1),
    .VOp_2     (vop2),
    .VOp_3     (vop3),
    .VOp_4     (vop4),
    .VOp_5     (vop5),
    .VOp_6     (vop6),
    .VOp_7     (vop7),
    .VRR_busy  (VRR_busy),
    .VRR_done  (VRR_done)
  );

  always_comb begin
    vop[0] = vop0; vop[1] = vop1; vop[2] = vop2; vop[3] = vop3;
    vop[4] = vop4; vop[5] = vop5; vop[6] = vop6; vop[7] = vop7;
  end

  // Register file: data valid the clock after the request cycle.
  always @(posedge clk) if (Read_En) Read_Data <= mem[Read_Addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is a timeline indexed by t = edges since the start edge.
  // Request k goes out at t=k, element k lands at t=k+2, done shows at t=eff+1, idle at eff+2.
  bit          m_active;
  int          m_t;
  int          m_eff;
  int          m_base;
  logic [31:0] m_vop [8];

  always @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
      for (int i = 0; i < 8; i++) m_vop[i] = 32'h0;
    end else if (!m_active) begin
      if (VRR_Ena) begin
        m_active = 1'b1;
        m_t      = 0;
        m_eff    = (VLR > 32'd8) ? 8 : int'(VLR);
        m_base   = int'(Base_Addr);
        for (int i = 0; i < 8; i++) m_vop[i] = 32'h0;
      end
    end else begin
      m_t++;
      if (m_t >= 2 && m_t - 2 < m_eff) m_vop[m_t-2] = mem[(m_base + m_t - 2) % 32];
      if (m_t == m_eff + 2) m_active = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_ren;
    exp_ren = m_active && (m_t < m_eff);
    chk("read_en", 32'(Read_En), 32'(exp_ren));
    if (exp_ren) chk("read_addr", 32'(Read_Addr), 32'((m_base + m_t) % 32));
    chk("busy", 32'(VRR_busy), 32'(m_active));
    chk("done", 32'(VRR_done), 32'(m_active && (m_t == m_eff + 1)));
    for (int i = 0; i < 8; i++) chk($sformatf("vop%0d", i), vop[i], m_vop[i]);
  end

  // One directed operation with literal expectations; assumes mem[a] = 0x100 + a.
  task automatic run_op(input logic [31:0] vlr, input logic [4:0] base, input int exp_eff,
                        input string name);
    int         edges;
    bit         got;
    logic [4:0] addrs [$];
    edges = 0;
    got   = 1'b0;
    @(negedge clk);
    VRR_Ena   = 1'b1;
    VLR       = vlr;
    Base_Addr = base;
    @(posedge clk);
    @(negedge clk);
    VRR_Ena   = 1'b0;
    VLR       = $urandom;
    Base_Addr = 5'($urandom);
    for (int c = 0; c < 20; c++) begin
      if (Read_En) addrs.push_back(Read_Addr);
      if (VRR_done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(edges), 32'(exp_eff + 1));
    chk({name, "_nreads"}, 32'(addrs.size()), 32'(exp_eff));
    foreach (addrs[i]) chk({name, "_addr"}, 32'(addrs[i]), 32'((int'(base) + i) % 32));
    for (int i = 0; i < 8; i++)
      chk({name, "_vop"}, vop[i], (i < exp_eff) ? 32'h100 + 32'((int'(base) + i) % 32) : 32'h0);
  endtask

  initial begin
    int dones [$];
    pc_rst_n  = 1'b0;
    VRR_Ena   = 1'b0;
    VLR       = 32'd0;
    Base_Addr = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);

    repeat (3) @(negedge clk);
    chk("rst_read_en", 32'(Read_En), 32'd0);
    chk("rst_read_addr", 32'(Read_Addr), 32'd0);
    chk("rst_busy", 32'(VRR_busy), 32'd0);
    chk("rst_done", 32'(VRR_done), 32'd0);
    chk("rst_vop0", vop0, 32'h0);
    @(posedge clk);
    #2 pc_rst_n = 1'b1;

    run_op(32'd8, 5'd0, 8, "full8");
    run_op(32'd3, 5'd4, 3, "len3");
    run_op(32'd0, 5'd9, 0, "len0");
    run_op(32'd20, 5'd0, 8, "clamp20");
    run_op(32'd4, 5'd30, 4, "wrap");

    // Reset in the middle of an 8-element operation.
    @(negedge clk);
    VRR_Ena   = 1'b1;
    VLR       = 32'd8;
    Base_Addr = 5'd0;
    @(posedge clk);
    @(negedge clk);
    VRR_Ena = 1'b0;
    repeat (3) @(posedge clk);
    #2 pc_rst_n = 1'b0;
    #1;
    chk("abort_read_en", 32'(Read_En), 32'd0);
    chk("abort_read_addr", 32'(Read_Addr), 32'd0);
    chk("abort_busy", 32'(VRR_busy), 32'd0);
    chk("abort_vop0", vop0, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #2 pc_rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(VRR_done), 32'd0);
    end
    run_op(32'd2, 5'd10, 2, "after_abort");

    // Continuous start request: a done pulse every eff+3 clocks.
    @(negedge clk);
    VRR_Ena   = 1'b1;
    VLR       = 32'd2;
    Base_Addr = 5'd3;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (VRR_done) dones.push_back(c);
    end
    chk("b2b_pulses", 32'(dones.size() >= 5), 32'd1);
    for (int i = 1; i < dones.size(); i++) chk("b2b_period", 32'(dones[i] - dones[i-1]), 32'd5);

    // Toggle the start request freely; the model decides which edges really start.
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      VRR_Ena   = 1'($urandom);
      VLR       = 32'd2;
      Base_Addr = 5'($urandom);
    end

    // Random operations over random memory contents.
    @(negedge clk);
    VRR_Ena = 1'b0;
    repeat (15) @(negedge clk);
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      VRR_Ena = ($urandom_range(2) != 0);
      case ($urandom_range(3))
        0:       VLR = 32'($urandom_range(8));
        1:       VLR = 32'($urandom_range(15));
        2:       VLR = $urandom;
        default: VLR = 32'd20;
      endcase
      Base_Addr = 5'($urandom);
    end
    @(negedge clk);
    VRR_Ena = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
